// File: rtl/d_mem_arbiter.sv
// Two-port arbiter/sequencer sharing the single-port d_mem between the CPU (port 0) and debug/DMA (port 1).
// Optional round-robin arbitration is enabled with `define D_MEM_ARB_RR_EN; otherwise fixed priority to port 0.
module d_mem_arbiter #(
  parameter int MemSize = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t      state, state_next;
  logic        gnt;
  logic        gnt_q;
  logic        we_q;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_bad;
  logic        any_req;
`ifdef D_MEM_ARB_RR_EN
  logic        ptr;
`endif

  always_comb begin
`ifdef D_MEM_ARB_RR_EN
    // Port 1 wins when alone, or on a tie when the pointer prefers it.
    gnt = req1 & (~req0 | ptr);
`else
    gnt = req1 & ~req0;
`endif
    any_req   = req0 | req1;
    sel_we    = gnt ? we1 : we0;
    sel_addr  = gnt ? addr1 : addr0;
    sel_wdata = gnt ? wdata1 : wdata0;
    addr_bad  = (sel_addr >> MemSize) != 32'd0;

    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = addr_bad ? RESP : ISSUE;
      ISSUE:   state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
`ifdef D_MEM_ARB_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q <= gnt;
            we_q  <= sel_we;
`ifdef D_MEM_ARB_RR_EN
            ptr   <= ~gnt;
`endif
            if (addr_bad) begin
              // Rejected before the memory: strobes stay low, mem_addr/mem_wdata hold.
              if (gnt) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
              end
            end else begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_write <= sel_we;
              mem_read  <= ~sel_we;
            end
          end
        end
        ISSUE: ;
        CAPT: begin
          if (gnt_q) begin
            ack1   <= 1'b1;
            rdata1 <= we_q ? '0 : mem_rdata;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= we_q ? '0 : mem_rdata;
          end
        end
        RESP: begin
          rdata0 <= '0;
          rdata1 <= '0;
          err0   <= 1'b0;
          err1   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
